// File: rtl/strm_pkg.sv
// Shared types for the stream checker: soft-register bundles,
// address map, checker state and the test pattern helper.
package strm_pkg;

    localparam int ID_W = 8;

    // Soft-register address map
    localparam logic [31:0] STRM_CHK_START  = 32'h00;
    localparam logic [31:0] STRM_CHK_PLEN   = 32'h08;
    localparam logic [31:0] STRM_CHK_EXP_ID = 32'h10;
    localparam logic [31:0] STRM_CHK_MASK   = 32'h18;
    localparam logic [31:0] STRM_CHK_STATUS = 32'h20;
    localparam logic [31:0] STRM_CHK_DERR   = 32'h28;
    localparam logic [31:0] STRM_CHK_LERR   = 32'h30;
    localparam logic [31:0] STRM_CHK_IDERR  = 32'h38;
    localparam logic [31:0] STRM_CHK_PKTS   = 32'h40;
    localparam logic [31:0] STRM_CHK_CYCLES = 32'h48;
    localparam logic [31:0] STRM_CHK_FEBEAT = 32'h50;
    localparam logic [31:0] STRM_CHK_FEDATA = 32'h58;

    // Bit positions in the beat error vector
    localparam int ERR_DATA = 0;
    localparam int ERR_LAST = 1;
    localparam int ERR_ID   = 2;

    typedef struct packed {
        logic        valid;
        logic        isWrite;
        logic [31:0] addr;
        logic [63:0] data;
    } SoftRegReq;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } SoftRegResp;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    // One 32-bit lane of the pattern; the beat is this word
    // replicated across every lane of tdata.
    function automatic logic [31:0] pattern_word(
        input logic [31:0] idx_lo
    );
        return idx_lo;
    endfunction

endpackage

// File: rtl/axi_stream_t.sv
// Virtual AXI-Stream bundle. The master modport is the receive
// view (drives tready); source is the transmit view.
interface axi_stream_t #(
    parameter int DATA_W = 512
) ();

    logic                      tvalid;
    logic                      tready;
    logic [DATA_W-1:0]         tdata;
    logic [strm_pkg::ID_W-1:0] tid;
    logic                      tlast;

    modport master (
        output tready,
        input  tvalid,
        input  tdata,
        input  tid,
        input  tlast
    );

    modport source (
        output tvalid,
        output tdata,
        output tid,
        output tlast,
        input  tready
    );

endinterface

// File: rtl/strm_beat_check.sv
// Combinational beat compare against the stream test pattern.
// Ports: tdata/tid/tlast beat, idx/packet_len/exp_id ref, err vector.
module strm_beat_check
    import strm_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int CNT_W  = 35
) (
    input  logic [DATA_W-1:0] tdata,
    input  logic [ID_W-1:0]   tid,
    input  logic              tlast,
    input  logic [CNT_W-1:0]  idx,
    input  logic [CNT_W-1:0]  packet_len,
    input  logic [ID_W-1:0]   exp_id,
    output logic [2:0]        err
);

    localparam int LANES = DATA_W / 32;

    logic [LANES-1:0] lane_bad;
    logic [31:0]      pat;

    assign pat = pattern_word(idx[31:0]);

    always_comb begin
        lane_bad = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_bad[l] = (tdata[l*32 +: 32] != pat);
        end
    end

    always_comb begin
        err           = '0;
        err[ERR_DATA] = |lane_bad;
        err[ERR_LAST] = tlast != (idx == packet_len);
        err[ERR_ID]   = tid != exp_id;
    end

endmodule

// File: rtl/axis_strm_check.sv
// Receive-side AXI-Stream traffic checker with soft-register control.
// Ports: clk, rst (sync high), softreg_req/resp, axis_s (rx, drives tready).
module axis_strm_check
    import strm_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int CNT_W  = 35,
    parameter int ERR_W  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  SoftRegReq   softreg_req,
    output SoftRegResp  softreg_resp,
    axi_stream_t.master axis_s
);

    chk_state_t       state;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] packet_len;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] beats;
    logic [CNT_W-1:0] packets;
    logic [CNT_W-1:0] cycles;
    logic [CNT_W-1:0] first_err_beat;
    logic [ID_W-1:0]  exp_id;
    logic [31:0]      ready_mask;
    logic [4:0]       mask_ptr;
    logic [ERR_W-1:0] data_err;
    logic [ERR_W-1:0] last_err;
    logic [ERR_W-1:0] id_err;
    logic             first_err_valid;
    logic [63:0]      first_err_data;

    logic [2:0]       beat_err;
    logic             wr_en;
    logic             rd_en;
    logic             start_wr;
    logic             hs;
    logic [CNT_W-1:0] wr_cnt;
    logic [63:0]      rd_data;
    logic             unused_req_bits;

    assign wr_en    = softreg_req.valid && softreg_req.isWrite;
    assign rd_en    = softreg_req.valid && !softreg_req.isWrite;
    assign start_wr = wr_en && (softreg_req.addr == STRM_CHK_START);
    assign wr_cnt   = softreg_req.data[CNT_W-1:0];

    assign unused_req_bits = ^softreg_req.data[63:CNT_W];

    // tready is a function of registered state only, never of tvalid
    assign axis_s.tready = (state == RUN)
                        && (remaining != '0)
                        && ready_mask[mask_ptr];

    assign hs = axis_s.tvalid && axis_s.tready;

    strm_beat_check #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_beat_check (
        .tdata      (axis_s.tdata),
        .tid        (axis_s.tid),
        .tlast      (axis_s.tlast),
        .idx        (idx),
        .packet_len (packet_len),
        .exp_id     (exp_id),
        .err        (beat_err)
    );

    function automatic logic [ERR_W-1:0] sat_inc(
        input logic [ERR_W-1:0] v,
        input logic             en
    );
        if (en && (v != '1)) begin
            return v + ERR_W'(1);
        end
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            remaining       <= '0;
            packet_len      <= '0;
            idx             <= '0;
            beats           <= '0;
            packets         <= '0;
            cycles          <= '0;
            first_err_beat  <= '0;
            exp_id          <= '0;
            ready_mask      <= 32'hFFFF_FFFF;
            mask_ptr        <= '0;
            data_err        <= '0;
            last_err        <= '0;
            id_err          <= '0;
            first_err_valid <= 1'b0;
            first_err_data  <= '0;
        end else begin
            if (state == RUN) begin
                mask_ptr <= mask_ptr + 5'd1;
                cycles   <= cycles + CNT_W'(1);
            end

            if (hs) begin
                remaining <= remaining - CNT_W'(1);
                beats     <= beats + CNT_W'(1);
                data_err  <= sat_inc(data_err, beat_err[ERR_DATA]);
                last_err  <= sat_inc(last_err, beat_err[ERR_LAST]);
                id_err    <= sat_inc(id_err, beat_err[ERR_ID]);
                // Always resync on the received tlast, even a bad one
                if (axis_s.tlast) begin
                    idx     <= '0;
                    packets <= packets + CNT_W'(1);
                end else begin
                    idx <= idx + CNT_W'(1);
                end
                if ((beat_err != '0) && !first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_beat  <= beats;
                    first_err_data  <= axis_s.tdata[63:0];
                end
                if (remaining == CNT_W'(1)) begin
                    state <= DONE;
                end
            end

            if (wr_en) begin
                case (softreg_req.addr)
                    STRM_CHK_PLEN:   packet_len <= wr_cnt;
                    STRM_CHK_EXP_ID: exp_id <= softreg_req.data[ID_W-1:0];
                    STRM_CHK_MASK:   ready_mask <= softreg_req.data[31:0];
                    default: ;
                endcase
            end

            // Start overrides any beat taken in the same cycle
            if (start_wr) begin
                remaining       <= wr_cnt;
                idx             <= '0;
                beats           <= '0;
                packets         <= '0;
                cycles          <= '0;
                data_err        <= '0;
                last_err        <= '0;
                id_err          <= '0;
                mask_ptr        <= '0;
                first_err_valid <= 1'b0;
                first_err_beat  <= '0;
                first_err_data  <= '0;
                state           <= (wr_cnt == '0) ? DONE : RUN;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (softreg_req.addr)
            STRM_CHK_START:  rd_data = 64'(remaining);
            STRM_CHK_PLEN:   rd_data = 64'(packet_len);
            STRM_CHK_EXP_ID: rd_data = 64'(exp_id);
            STRM_CHK_MASK:   rd_data = 64'(ready_mask);
            STRM_CHK_STATUS: rd_data = 64'({first_err_valid, state});
            STRM_CHK_DERR:   rd_data = 64'(data_err);
            STRM_CHK_LERR:   rd_data = 64'(last_err);
            STRM_CHK_IDERR:  rd_data = 64'(id_err);
            STRM_CHK_PKTS:   rd_data = 64'(packets);
            STRM_CHK_CYCLES: rd_data = 64'(cycles);
            STRM_CHK_FEBEAT: rd_data = 64'(first_err_beat);
            STRM_CHK_FEDATA: rd_data = first_err_data;
            default:         rd_data = '0;
        endcase
    end

    // Registered response; reads see pre-write values
    always_ff @(posedge clk) begin
        if (rst) begin
            softreg_resp <= '0;
        end else begin
            softreg_resp.valid <= rd_en;
            softreg_resp.data  <= rd_en ? rd_data : '0;
        end
    end

endmodule

// File: tb/tb_axis_strm_check.sv
// Testbench for axis_strm_check: directed and random traffic
// checked against a beat-level reference model.
module tb_axis_strm_check;
    import strm_pkg::*;

    localparam int DATA_W = 512;
    localparam int CNT_W  = 35;
    localparam int ERR_W  = 32;
    localparam int LANES  = DATA_W / 32;
    localparam longint CNT_MASK = (64'd1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst;
    SoftRegReq  req;
    SoftRegResp resp;

    axi_stream_t #(.DATA_W(DATA_W)) axis ();

    axis_strm_check #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .ERR_W  (ERR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .softreg_req  (req),
        .softreg_resp (resp),
        .axis_s       (axis)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    longint      m_rem, m_plen, m_eid, m_mask;
    longint      m_derr, m_lerr, m_iderr;
    longint      m_pkts, m_beats, m_idx, m_cyc, m_feb;
    logic [63:0] m_fed;
    bit          m_fev;
    int          m_state;
    bit          m_cyc_known;

    logic [63:0] rd_val [12];
    bit          rd_vld [12];

    function automatic logic [DATA_W-1:0] pat(input longint i);
        logic [31:0] w;
        w = i[31:0];
        return {LANES{w}};
    endfunction

    function automatic void model_reset();
        m_rem = 0; m_plen = 0; m_eid = 0; m_mask = 64'hFFFF_FFFF;
        m_derr = 0; m_lerr = 0; m_iderr = 0;
        m_pkts = 0; m_beats = 0; m_idx = 0; m_cyc = 0; m_feb = 0;
        m_fed = 0; m_fev = 0; m_state = 0; m_cyc_known = 1;
    endfunction

    function automatic void model_start(input logic [63:0] d);
        m_rem = longint'(d) & CNT_MASK;
        m_derr = 0; m_lerr = 0; m_iderr = 0;
        m_pkts = 0; m_beats = 0; m_idx = 0; m_cyc = 0; m_feb = 0;
        m_fed = 0; m_fev = 0; m_cyc_known = 0;
        m_state = (m_rem == 0) ? 2 : 1;
    endfunction

    function automatic void model_beat(
        input logic [DATA_W-1:0] d,
        input logic [7:0]        id,
        input bit                last
    );
        bit de, le, ie;
        de = (d !== pat(m_idx));
        le = (last != (m_idx == m_plen));
        ie = (id != m_eid[7:0]);
        if (de && m_derr < 64'hFFFF_FFFF) m_derr++;
        if (le && m_lerr < 64'hFFFF_FFFF) m_lerr++;
        if (ie && m_iderr < 64'hFFFF_FFFF) m_iderr++;
        if ((de || le || ie) && !m_fev) begin
            m_fev = 1;
            m_feb = m_beats;
            m_fed = d[63:0];
        end
        m_beats++;
        m_rem--;
        if (m_rem == 0) m_state = 2;
        if (last) begin
            m_idx = 0;
            m_pkts++;
        end else begin
            m_idx = (m_idx + 1) & CNT_MASK;
        end
    endfunction

    function automatic logic [63:0] model_reg(input int k);
        logic [1:0] st;
        st = m_state[1:0];
        case (k)
            0:  return m_rem;
            1:  return m_plen;
            2:  return m_eid;
            3:  return m_mask;
            4:  return {61'd0, m_fev, st};
            5:  return m_derr;
            6:  return m_lerr;
            7:  return m_iderr;
            8:  return m_pkts;
            9:  return m_cyc;
            10: return m_feb;
            default: return m_fed;
        endcase
    endfunction

    function automatic longint bp_cycles(
        input logic [31:0] m,
        input int          n
    );
        int cnt;
        int k;
        cnt = 0;
        k = 0;
        while (cnt < n) begin
            if (m[k % 32]) cnt++;
            k++;
        end
        return longint'(k);
    endfunction

    task automatic sr_write(input logic [31:0] a, input logic [63:0] d);
        req.valid = 1'b1;
        req.isWrite = 1'b1;
        req.addr = a;
        req.data = d;
        @(posedge clk);
        @(negedge clk);
        req.valid = 1'b0;
        req.isWrite = 1'b0;
        case (a)
            STRM_CHK_START:  model_start(d);
            STRM_CHK_PLEN:   m_plen = longint'(d) & CNT_MASK;
            STRM_CHK_EXP_ID: m_eid = longint'(d) & 64'hFF;
            STRM_CHK_MASK:   m_mask = longint'(d) & 64'hFFFF_FFFF;
            default: ;
        endcase
    endtask

    task automatic sr_read(
        input  logic [31:0] a,
        output logic [63:0] d,
        output bit          v
    );
        req.valid = 1'b1;
        req.isWrite = 1'b0;
        req.addr = a;
        req.data = '0;
        @(posedge clk);
        @(negedge clk);
        req.valid = 1'b0;
        v = resp.valid;
        d = resp.data;
    endtask

    task automatic read_all();
        for (int k = 0; k < 12; k++) begin
            sr_read(32'(k * 8), rd_val[k], rd_vld[k]);
        end
    endtask

    task automatic send_beat(
        input logic [DATA_W-1:0] d,
        input logic [7:0]        id,
        input bit                last
    );
        bit hs;
        bit ok;
        ok = 0;
        axis.tvalid = 1'b1;
        axis.tdata = d;
        axis.tid = id;
        axis.tlast = last;
        for (int i = 0; i < 200 && !ok; i++) begin
            hs = axis.tready;
            @(posedge clk);
            @(negedge clk);
            if (hs) begin
                ok = 1;
                model_beat(d, id, last);
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL beat_timeout got=no_handshake exp=handshake");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        total++;
        if (axis.tready !== 1'b0 || resp.valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_outs tready=%b rvalid=%b exp=0/0",
                     axis.tready, resp.valid);
        end
        read_all();
        for (int k = 0; k < 12; k++) begin
            if (k == 9 && !m_cyc_known) continue;
            total++;
            if (!rd_vld[k] || rd_val[k] !== model_reg(k)) begin
                bad++;
                $display("FAIL reset reg%02h got=%h v=%0d exp=%h",
                         k * 8, rd_val[k], rd_vld[k], model_reg(k));
            end
        end
    endtask

    task automatic test_clean();
        sr_write(STRM_CHK_PLEN, 3);
        sr_write(STRM_CHK_EXP_ID, 2);
        sr_write(STRM_CHK_START, 8);
        for (int i = 0; i < 8; i++) begin
            send_beat(pat(i % 4), 8'd2, (i % 4) == 3);
        end
        axis.tvalid = 1'b0;
        m_cyc = 8;
        m_cyc_known = 1;
        read_all();
        for (int k = 0; k < 12; k++) begin
            if (k == 9 && !m_cyc_known) continue;
            total++;
            if (!rd_vld[k] || rd_val[k] !== model_reg(k)) begin
                bad++;
                $display("FAIL clean reg%02h got=%h v=%0d exp=%h",
                         k * 8, rd_val[k], rd_vld[k], model_reg(k));
            end
        end
    endtask

    task automatic test_corrupt();
        logic [DATA_W-1:0] d;
        sr_write(STRM_CHK_PLEN, 3);
        sr_write(STRM_CHK_START, 4);
        for (int i = 0; i < 4; i++) begin
            d = pat(i);
            if (i == 2) d[5*32 +: 32] = 32'hDEAD;
            send_beat(d, 8'd2, i == 3);
        end
        axis.tvalid = 1'b0;
        m_cyc = 4;
        m_cyc_known = 1;
        read_all();
        for (int k = 0; k < 12; k++) begin
            if (k == 9 && !m_cyc_known) continue;
            total++;
            if (!rd_vld[k] || rd_val[k] !== model_reg(k)) begin
                bad++;
                $display("FAIL corrupt reg%02h got=%h v=%0d exp=%h",
                         k * 8, rd_val[k], rd_vld[k], model_reg(k));
            end
        end
    endtask

    task automatic test_early_tlast();
        sr_write(STRM_CHK_PLEN, 3);
        sr_write(STRM_CHK_START, 6);
        send_beat(pat(0), 8'd2, 1'b0);
        send_beat(pat(1), 8'd2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send_beat(pat(i), 8'd2, i == 3);
        end
        axis.tvalid = 1'b0;
        m_cyc = 6;
        m_cyc_known = 1;
        read_all();
        for (int k = 0; k < 12; k++) begin
            if (k == 9 && !m_cyc_known) continue;
            total++;
            if (!rd_vld[k] || rd_val[k] !== model_reg(k)) begin
                bad++;
                $display("FAIL early_tlast reg%02h got=%h v=%0d exp=%h",
                         k * 8, rd_val[k], rd_vld[k], model_reg(k));
            end
        end
    endtask

    task automatic test_plen0();
        sr_write(STRM_CHK_PLEN, 0);
        sr_write(STRM_CHK_START, 6);
        for (int i = 0; i < 6; i++) begin
            send_beat(pat(0), 8'd2, 1'b1);
        end
        axis.tvalid = 1'b0;
        m_cyc = 6;
        m_cyc_known = 1;
        read_all();
        for (int k = 0; k < 12; k++) begin
            if (k == 9 && !m_cyc_known) continue;
            total++;
            if (!rd_vld[k] || rd_val[k] !== model_reg(k)) begin
                bad++;
                $display("FAIL plen0 reg%02h got=%h v=%0d exp=%h",
                         k * 8, rd_val[k], rd_vld[k], model_reg(k));
            end
        end
    endtask

    task automatic test_saturation();
        logic [DATA_W-1:0] d;
        sr_write(STRM_CHK_PLEN, 3);
        sr_write(STRM_CHK_START, 2);
        force dut.data_err = 32'hFFFF_FFFF;
        #1;
        release dut.data_err;
        m_derr = 64'hFFFF_FFFF;
        d = pat(0);
        d[31:0] = 32'h1234_5678;
        send_beat(d, 8'd2, 1'b0);
        send_beat(pat(1), 8'd2, 1'b0);
        axis.tvalid = 1'b0;
        m_cyc = 2;
        m_cyc_known = 1;
        read_all();
        for (int k = 0; k < 12; k++) begin
            if (k == 9 && !m_cyc_known) continue;
            total++;
            if (!rd_vld[k] || rd_val[k] !== model_reg(k)) begin
                bad++;
                $display("FAIL saturate reg%02h got=%h v=%0d exp=%h",
                         k * 8, rd_val[k], rd_vld[k], model_reg(k));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] mask;
        int          acc;
        int          k;
        bit          tr;
        for (int p = 0; p < 2; p++) begin
            mask = (p == 0) ? 32'h5555_5555 : ($urandom() | 32'h1);
            sr_write(STRM_CHK_PLEN, 15);
            sr_write(STRM_CHK_MASK, 64'(mask));
            sr_write(STRM_CHK_START, 16);
            acc = 0;
            k = 0;
            while (acc < 16 && k < 200) begin
                axis.tvalid = 1'b1;
                axis.tdata = pat(acc);
                axis.tid = m_eid[7:0];
                axis.tlast = (acc == 15);
                total++;
                if (axis.tready !== mask[k % 32]) begin
                    bad++;
                    $display("FAIL bp_tready cyc=%0d got=%b exp=%b",
                             k, axis.tready, mask[k % 32]);
                end
                tr = axis.tready;
                @(posedge clk);
                @(negedge clk);
                if (tr) begin
                    model_beat(axis.tdata, axis.tid, axis.tlast);
                    acc++;
                end
                k++;
            end
            axis.tvalid = 1'b0;
            m_cyc = bp_cycles(mask, 16);
            m_cyc_known = 1;
            total++;
            if (axis.tready !== 1'b0) begin
                bad++;
                $display("FAIL bp_done_tready got=%b exp=0", axis.tready);
            end
            read_all();
            for (int j = 0; j < 12; j++) begin
                if (j == 9 && !m_cyc_known) continue;
                total++;
                if (!rd_vld[j] || rd_val[j] !== model_reg(j)) begin
                    bad++;
                    $display("FAIL bp%0d reg%02h got=%h v=%0d exp=%h",
                             p, j * 8, rd_val[j], rd_vld[j], model_reg(j));
                end
            end
        end
    endtask

    task automatic test_restart_reset();
        sr_write(STRM_CHK_MASK, 64'hFFFF_FFFF);
        sr_write(STRM_CHK_PLEN, 3);
        sr_write(STRM_CHK_EXP_ID, 2);
        sr_write(STRM_CHK_START, 100);
        for (int i = 0; i < 10; i++) begin
            send_beat(pat(i % 4), 8'd2, (i % 4) == 3);
        end
        // start write collides with an accepted beat
        axis.tvalid = 1'b1;
        axis.tdata = pat(2);
        axis.tid = 8'd2;
        axis.tlast = 1'b0;
        req.valid = 1'b1;
        req.isWrite = 1'b1;
        req.addr = STRM_CHK_START;
        req.data = 64'd5;
        total++;
        if (axis.tready !== 1'b1) begin
            bad++;
            $display("FAIL collide_tready got=%b exp=1", axis.tready);
        end
        @(posedge clk);
        @(negedge clk);
        req.valid = 1'b0;
        req.isWrite = 1'b0;
        axis.tvalid = 1'b0;
        model_start(5);
        send_beat(pat(0), 8'd7, 1'b0);
        axis.tvalid = 1'b0;
        read_all();
        for (int k = 0; k < 12; k++) begin
            if (k == 9 && !m_cyc_known) continue;
            total++;
            if (!rd_vld[k] || rd_val[k] !== model_reg(k)) begin
                bad++;
                $display("FAIL restart reg%02h got=%h v=%0d exp=%h",
                         k * 8, rd_val[k], rd_vld[k], model_reg(k));
            end
        end
        send_beat(pat(1), 8'd2, 1'b0);
        axis.tdata = pat(2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        axis.tvalid = 1'b0;
        model_reset();
        total++;
        if (axis.tready !== 1'b0) begin
            bad++;
            $display("FAIL midrst_tready got=%b exp=0", axis.tready);
        end
        read_all();
        for (int k = 0; k < 12; k++) begin
            if (k == 9 && !m_cyc_known) continue;
            total++;
            if (!rd_vld[k] || rd_val[k] !== model_reg(k)) begin
                bad++;
                $display("FAIL midrst reg%02h got=%h v=%0d exp=%h",
                         k * 8, rd_val[k], rd_vld[k], model_reg(k));
            end
        end
    endtask

    task automatic test_unmapped();
        logic [63:0] d;
        bit          v;
        sr_read(32'h60, d, v);
        total++;
        if (v !== 1'b1 || d !== 64'd0) begin
            bad++;
            $display("FAIL unmapped got=%h v=%0d exp=0 v=1", d, v);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (resp.valid !== 1'b0) begin
            bad++;
            $display("FAIL resp_pulse got=%b exp=0", resp.valid);
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] d;
        logic [7:0]        id;
        logic [7:0]        eid;
        logic [31:0]       mask;
        bit                last;
        longint            gi;
        int                plen;
        int                n;
        int                lane;
        for (int r = 0; r < 6; r++) begin
            plen = $urandom_range(0, 4);
            eid = 8'($urandom_range(0, 255));
            mask = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF
                                                : ($urandom() | 32'h1);
            n = $urandom_range(8, 30);
            sr_write(STRM_CHK_PLEN, 64'(plen));
            sr_write(STRM_CHK_EXP_ID, 64'(eid));
            sr_write(STRM_CHK_MASK, 64'(mask));
            sr_write(STRM_CHK_START, 64'(n));
            gi = 0;
            for (int b = 0; b < n; b++) begin
                d = pat(gi);
                id = eid;
                last = (gi == plen);
                lane = $urandom_range(0, LANES - 1);
                case ($urandom_range(0, 9))
                    0: d[lane*32 +: 32] = d[lane*32 +: 32] ^ ($urandom() | 32'h1);
                    1: id = eid ^ 8'($urandom_range(1, 255));
                    2: last = !last;
                    default: ;
                endcase
                send_beat(d, id, last);
                gi = last ? 0 : gi + 1;
                if ($urandom_range(0, 3) == 0) begin
                    axis.tvalid = 1'b0;
                    repeat ($urandom_range(1, 2)) @(negedge clk);
                end
            end
            axis.tvalid = 1'b0;
            read_all();
            for (int k = 0; k < 12; k++) begin
                if (k == 9 && !m_cyc_known) continue;
                total++;
                if (!rd_vld[k] || rd_val[k] !== model_reg(k)) begin
                    bad++;
                    $display("FAIL rand%0d reg%02h got=%h v=%0d exp=%h",
                             r, k * 8, rd_val[k], rd_vld[k], model_reg(k));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        axis.tvalid = 1'b0;
        axis.tdata = '0;
        axis.tid = '0;
        axis.tlast = 1'b0;
        model_reset();
        test_reset();
        test_clean();
        test_corrupt();
        test_early_tlast();
        test_plen0();
        test_saturation();
        test_backpressure();
        test_restart_reset();
        test_unmapped();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
